deserializador: RTL and testbench

Serial-to-parallel input stage feeding the 8-entry queue. Collects one serial bit per qualified clock cycle into an 8-bit word, MSB first. Holds the completed word on `data_out` and issues a single-cycle `enqueue_out` pulse to the queue once the queue reports not-full. While holding a word it refuses new bits and signals this on `status_out`, so the serial source can throttle.

---
 rtl/deser_pkg.sv | 14 +
 rtl/deserializador.sv | 103 ++++++++++
 tb/tb_deserializador.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel input stage.
package deser_pkg;

  // Controller states: gathering bits, waiting for queue space, issuing the push strobe.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    PUSH    = 2'd2
  } deser_state_t;

  // Default word width; also fixes the bit-count terminal value.
  localparam int WORD_W = 8;

endpackage : deser_pkg

// File: rtl/deserializador.sv
// Serial-to-parallel input stage: shifts in one bit per qualified cycle (MSB first),
// holds the completed word and hands it to the downstream queue with a one-cycle
// enqueue strobe once the queue has room. All outputs are registered.
module deserializador #(
  parameter int WORD_W = deser_pkg::WORD_W
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              data_in,
  input  logic              write_in,
  input  logic              full_in,
  output logic [WORD_W-1:0] data_out,
  output logic              enqueue_out,
  output logic              status_out
);

  import deser_pkg::deser_state_t;
  import deser_pkg::COLLECT;
  import deser_pkg::HOLD;
  import deser_pkg::PUSH;

  localparam int              CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  deser_state_t      r_state;
  deser_state_t      w_state_next;
  logic [WORD_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_count;
  logic [WORD_W-1:0] r_data;
  logic              r_enq;
  logic              r_status;

  logic              w_accept;
  logic              w_last;
  logic [WORD_W-1:0] w_word;

  // The accepted bit is the final one of the word when the count sits at its terminal value.
  assign w_last = (r_count == LAST_CNT);
  // Word as it will look once the current serial bit is shifted in.
  assign w_word = {r_shreg[WORD_W-2:0], data_in};

  // Next-state logic; bits are only taken while collecting, dropped otherwise.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      COLLECT: begin
        w_accept = write_in;
        if (write_in && w_last) begin
          w_state_next = HOLD;
        end else begin
          w_state_next = COLLECT;
        end
      end
      HOLD: begin
        if (!full_in) begin
          w_state_next = PUSH;
        end else begin
          w_state_next = HOLD;
        end
      end
      PUSH: begin
        w_state_next = COLLECT;
      end
      default: begin
        w_state_next = COLLECT;
      end
    endcase
  end

  // State, datapath and registered Moore outputs (decoded from the next state so they
  // line up with the state register without a combinational output path).
  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      r_state  <= COLLECT;
      r_shreg  <= {WORD_W{1'b0}};
      r_count  <= CNT_ZERO;
      r_data   <= {WORD_W{1'b0}};
      r_enq    <= 1'b0;
      r_status <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_enq    <= (w_state_next == PUSH);
      r_status <= (w_state_next == COLLECT);
      if (w_accept) begin
        r_shreg <= w_word;
        if (w_last) begin
          r_count <= CNT_ZERO;
          r_data  <= w_word;
        end else begin
          r_count <= r_count + CNT_ONE;
        end
      end
    end
  end

  assign data_out    = r_data;
  assign enqueue_out = r_enq;
  assign status_out  = r_status;

endmodule : deserializador

// File: tb/tb_deserializador.sv
// Self-checking bench for deserializador: a per-cycle reference model plus directed
// scenarios with literal expectations, and a small behavioural 8-deep queue.
`timescale 1ns/1ps
module tb_deserializador;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       full_in;
  logic [7:0] data_out;
  logic       enqueue_out;
  logic       status_out;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;
  bit use_q   = 1'b0;
  int n_push  = 0;
  int fifo[$];

  // reference model state
  bit         m_bits[$];
  logic [7:0] m_data;
  bit         m_hold;
  bit         m_push;
  logic       m_enq;
  logic       m_status;

  deserializador #(.WORD_W(8)) dut (
    .clk_10KHz  (clk),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .full_in    (full_in),
    .data_out   (data_out),
    .enqueue_out(enqueue_out),
    .status_out (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: bits gathered in a list, word formed arithmetically when 8 are in.
  always @(posedge clk) begin
    if (reset) begin
      m_bits.delete();
      m_data = 8'h00;
      m_hold = 1'b0;
      m_push = 1'b0;
    end else if (m_push) begin
      m_push = 1'b0;
    end else if (m_hold) begin
      if (!full_in) begin
        m_hold = 1'b0;
        m_push = 1'b1;
      end
    end else if (write_in) begin
      m_bits.push_back(data_in);
      if (m_bits.size() == 8) begin
        int w;
        w = 0;
        for (int i = 0; i < 8; i++) w = w * 2 + int'(m_bits[i]);
        m_data = w[7:0];
        m_bits.delete();
        m_hold = 1'b1;
      end
    end
    m_enq    = m_push;
    m_status = !(m_hold || m_push);
  end

  // Behavioural queue: captures the word on every edge where the strobe was high.
  always @(posedge clk) begin
    if (chk_en && enqueue_out === 1'b1) begin
      fifo.push_back(int'(data_out));
      n_push++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_data", 32'(data_out), 32'(m_data));
      chk("cyc_enq", 32'(enqueue_out), 32'(m_enq));
      chk("cyc_status", 32'(status_out), 32'(m_status));
    end
  end

  task automatic step(input bit w, input bit d, input bit rst = 1'b0);
    reset    = rst;
    write_in = w;
    data_in  = d;
    if (use_q) full_in = (fifo.size() >= 8);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, b[i]);
      if (i != 0) repeat (gap) step(1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  initial begin
    int p0;
    int v;
    reset = 1'b1; data_in = 1'b0; write_in = 1'b0; full_in = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_enq", 32'(enqueue_out), 32'h0);
    chk("rst_status", 32'(status_out), 32'h1);

    // basic word
    p0 = n_push;
    send_byte(8'hA5);
    chk("basic_data", 32'(data_out), 32'hA5);
    chk("basic_status_hold", 32'(status_out), 32'h0);
    chk("basic_enq_hold", 32'(enqueue_out), 32'h0);
    idle(1);
    chk("basic_enq_push", 32'(enqueue_out), 32'h1);
    chk("basic_status_push", 32'(status_out), 32'h0);
    idle(1);
    chk("basic_enq_after", 32'(enqueue_out), 32'h0);
    chk("basic_status_after", 32'(status_out), 32'h1);
    chk("basic_pushes", 32'(n_push - p0), 32'd1);
    chk("basic_q_word", 32'(fifo[fifo.size()-1]), 32'hA5);

    // gapped input, starting from a cleared output register
    step(1'b0, 1'b0, 1'b1);
    send_byte(8'hA5, 1);
    chk("gap_data", 32'(data_out), 32'hA5);
    idle(2);

    // partial word leaves data_out alone
    send_byte(8'h3C);
    idle(2);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    chk("partial_keeps_data", 32'(data_out), 32'h3C);
    step(1'b0, 1'b0, 1'b1);

    // backpressure
    p0 = n_push;
    full_in = 1'b1;
    send_byte(8'h3C);
    chk("bp_data", 32'(data_out), 32'h3C);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      chk("bp_enq_low", 32'(enqueue_out), 32'h0);
      chk("bp_status_low", 32'(status_out), 32'h0);
    end
    full_in = 1'b0;
    idle(1);
    chk("bp_enq_release", 32'(enqueue_out), 32'h1);
    idle(1);
    chk("bp_pushes", 32'(n_push - p0), 32'd1);

    // bits offered during HOLD and PUSH are dropped
    send_byte(8'hC3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    send_byte(8'h00);
    chk("drop_data", 32'(data_out), 32'h00);
    idle(2);

    // reset mid-word
    p0 = n_push;
    repeat (4) step(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    send_byte(8'hF0);
    chk("rstmid_data", 32'(data_out), 32'hF0);
    idle(2);
    chk("rstmid_pushes", 32'(n_push - p0), 32'd1);

    // reset while holding
    p0 = n_push;
    full_in = 1'b1;
    send_byte(8'h77);
    chk("rsthold_data_pre", 32'(data_out), 32'h77);
    step(1'b0, 1'b0, 1'b1);
    chk("rsthold_data", 32'(data_out), 32'h00);
    chk("rsthold_enq", 32'(enqueue_out), 32'h0);
    chk("rsthold_status", 32'(status_out), 32'h1);
    full_in = 1'b0;
    idle(3);
    chk("rsthold_pushes", 32'(n_push - p0), 32'd0);

    // back-to-back into the 8-deep queue
    step(1'b0, 1'b0, 1'b1);
    fifo.delete();
    use_q = 1'b1;
    for (int w = 1; w <= 9; w++) begin
      send_byte(8'(w));
      idle(2);
    end
    idle(3);
    chk("q_len_full", 32'(fifo.size()), 32'd8);
    chk("q_stall_data", 32'(data_out), 32'h09);
    chk("q_stall_status", 32'(status_out), 32'h0);
    chk("q_stall_enq", 32'(enqueue_out), 32'h0);
    v = fifo.pop_front();
    chk("q_deq_word", 32'(v), 32'h01);
    idle(1);
    chk("q_enq_resume", 32'(enqueue_out), 32'h1);
    idle(1);
    chk("q_len_after", 32'(fifo.size()), 32'd8);
    chk("q_last_word", 32'(fifo[fifo.size()-1]), 32'h09);
    use_q = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_deserializador
